// File: rtl/pga_agc_controller.sv
// Automatic gain control loop that drives the PGA SPI interface from windowed ADC peak levels.
// Optional macro PGA_AGC_DONE_TIMEOUT_EN adds a done-wait timeout with sticky flag and retry.
module pga_agc_controller #(
  parameter int          SAMPLE_W       = 12,
  parameter int          WINDOW_LEN     = 1024,
  parameter int          SETTLE_CYCLES  = 256,
  parameter int          HIGH_THRESH    = 1800,
  parameter int          LOW_THRESH     = 450,
  parameter logic [7:0]  GAIN_INIT      = 8'd32,
  parameter logic [7:0]  GAIN_MIN       = 8'd0,
  parameter logic [7:0]  GAIN_MAX       = 8'd255,
  parameter logic [7:0]  GAIN_STEP      = 8'd4,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  input  logic                       pga_done_i,
  output logic [7:0]                 pga_gain_o,
  output logic                       pga_set_o,
  output logic                       busy_o,
  output logic [SAMPLE_W-2:0]        peak_o,
  output logic                       timeout_o
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int WIN_W = $clog2(WINDOW_LEN);
  localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_LEN - 1);
  localparam logic [STL_W-1:0] SETTLE_LOAD = STL_W'(SETTLE_CYCLES - 1);
  localparam logic [MAG_W-1:0] HIGH_T      = MAG_W'(HIGH_THRESH);
  localparam logic [MAG_W-1:0] LOW_T       = MAG_W'(LOW_THRESH);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_MEASURE, S_DECIDE, S_SET, S_WAIT_DONE, S_SETTLE
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [7:0]         r_gain;
  logic [7:0]         w_gainNext;
  logic [MAG_W-1:0]   r_peak;
  logic [MAG_W-1:0]   r_peakRun;
  logic [MAG_W-1:0]   w_mag;
  logic [MAG_W-1:0]   w_peakMax;
  logic [SAMPLE_W-1:0] w_sampleNeg;
  logic [WIN_W-1:0]   r_sampleCnt;
  logic [STL_W-1:0]   r_settleCnt;
  logic [8:0]         w_gainDn;
  logic [8:0]         w_gainUp;
  logic               w_timeoutHit;

  // The most negative sample has no positive twin, so it saturates to full scale.
  assign w_sampleNeg = -sample_i;
  always_comb begin
    w_mag = sample_i[SAMPLE_W-2:0];
    if (sample_i[SAMPLE_W-1]) begin
      if (w_sampleNeg[SAMPLE_W-1]) w_mag = '1;
      else                         w_mag = w_sampleNeg[SAMPLE_W-2:0];
    end
  end
  assign w_peakMax = (w_mag > r_peakRun) ? w_mag : r_peakRun;

  assign w_gainDn = {1'b0, r_gain} - {1'b0, GAIN_STEP};
  assign w_gainUp = {1'b0, r_gain} + {1'b0, GAIN_STEP};
  always_comb begin
    w_gainNext = r_gain;
    if (r_peak >= HIGH_T && r_gain > GAIN_MIN) begin
      if ({1'b0, r_gain} < ({1'b0, GAIN_MIN} + {1'b0, GAIN_STEP})) w_gainNext = GAIN_MIN;
      else                                                       w_gainNext = w_gainDn[7:0];
    end else if (r_peak < LOW_T && r_gain < GAIN_MAX) begin
      if (w_gainUp > {1'b0, GAIN_MAX}) w_gainNext = GAIN_MAX;
      else                             w_gainNext = w_gainUp[7:0];
    end
  end

`ifdef PGA_AGC_DONE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_toCnt;
  logic            r_timeout;

  assign w_timeoutHit = (r_toCnt == TO_LAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toCnt   <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_WAIT_DONE && !pga_done_i) begin
      if (w_timeoutHit) begin
        r_toCnt   <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_toCnt <= r_toCnt + 1'b1;
      end
    end else begin
      r_toCnt <= '0;
    end
  end
  assign timeout_o = r_timeout;
`else
  assign w_timeoutHit = 1'b0;
  assign timeout_o    = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_INIT:      w_stateNext = S_SET;
      S_IDLE:      if (enable_i) w_stateNext = S_MEASURE;
      S_MEASURE: begin
        if (!enable_i)                                      w_stateNext = S_IDLE;
        else if (sample_valid_i && r_sampleCnt == WIN_LAST) w_stateNext = S_DECIDE;
      end
      S_DECIDE:    w_stateNext = (w_gainNext != r_gain) ? S_SET : S_MEASURE;
      S_SET:       w_stateNext = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (pga_done_i)        w_stateNext = S_SETTLE;
        else if (w_timeoutHit) w_stateNext = S_SET;
      end
      S_SETTLE:    if (r_settleCnt == '0) w_stateNext = enable_i ? S_MEASURE : S_IDLE;
      default:     w_stateNext = S_INIT;
    endcase
  end

  // Window accumulation only runs in MEASURE; leaving it any other way discards the partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gain      <= GAIN_INIT;
      r_peak      <= '0;
      r_peakRun   <= '0;
      r_sampleCnt <= '0;
      r_settleCnt <= '0;
    end else begin
      case (r_state)
        S_MEASURE: begin
          if (!enable_i) begin
            r_sampleCnt <= '0;
            r_peakRun   <= '0;
          end else if (sample_valid_i) begin
            if (r_sampleCnt == WIN_LAST) begin
              r_peak      <= w_peakMax;
              r_peakRun   <= '0;
              r_sampleCnt <= '0;
            end else begin
              r_peakRun   <= w_peakMax;
              r_sampleCnt <= r_sampleCnt + 1'b1;
            end
          end
        end
        S_DECIDE:    r_gain <= w_gainNext;
        S_WAIT_DONE: if (pga_done_i) r_settleCnt <= SETTLE_LOAD;
        S_SETTLE:    if (r_settleCnt != '0) r_settleCnt <= r_settleCnt - 1'b1;
        default: begin
          r_sampleCnt <= '0;
          r_peakRun   <= '0;
        end
      endcase
    end
  end

  assign pga_gain_o = r_gain;
  assign peak_o     = r_peak;
  assign pga_set_o  = (r_state == S_SET);
  assign busy_o     = (r_state == S_SET) || (r_state == S_WAIT_DONE) || (r_state == S_SETTLE);

endmodule
